// File: rtl/replacer_history_ctrl_pkg.sv
// Shared encodings for the NRU replacement-history controller:
// request opcodes, FSM states and the set-address width helper.
package replacer_pkg;

  localparam logic OP_TOUCH  = 1'b0;
  localparam logic OP_VICTIM = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ,
    ST_UPDATE,
    ST_RESP
  } state_t;

  function automatic int set_addr_width(input int num_set);
    return (num_set > 1) ? $clog2(num_set) : 1;
  endfunction

endpackage

// File: rtl/replacer_history_ctrl_if.sv
// Request/response bus of the replacement-history controller; the
// requester drives through the master modport, the controller is the slave.
interface replacer_history_ctrl_if #(
  parameter int NUM_WAY        = 8,
  parameter int SET_ADDR_WIDTH = 6
);

  logic                      request_valid_in;
  logic                      request_ready_out;
  logic                      request_op_in;
  logic [SET_ADDR_WIDTH-1:0] request_set_addr_in;
  logic [NUM_WAY-1:0]        request_way_in;
  logic [NUM_WAY-1:0]        request_valid_flatted_in;
  logic                      response_valid_out;
  logic                      response_ready_in;
  logic [NUM_WAY-1:0]        response_way_out;

  modport master (
    output request_valid_in, request_op_in, request_set_addr_in,
           request_way_in, request_valid_flatted_in, response_ready_in,
    input  request_ready_out, response_valid_out, response_way_out
  );

  modport slave (
    input  request_valid_in, request_op_in, request_set_addr_in,
           request_way_in, request_valid_flatted_in, response_ready_in,
    output request_ready_out, response_valid_out, response_way_out
  );

endinterface

// File: rtl/replacer_history_ctrl_ffo.sv
// Priority picker: isolates the lowest set bit of a vector as a one-hot
// mask and flags whether any bit was set at all.
module find_first_one_index #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [WIDTH-1:0] o_onehot,
  output logic             o_found
);

  // Two's-complement trick: x & -x keeps only the least significant one.
  assign o_onehot = i_vec & (~i_vec + WIDTH'(1));
  assign o_found  = |i_vec;

endmodule

// File: rtl/replacer_history_ctrl.sv
// NRU replacement-history controller: per-set history bits, TOUCH updates
// on hits and VICTIM selection on misses, one request every four cycles.
module replacer_history_ctrl
  import replacer_pkg::*;
#(
  parameter int NUM_WAY = 8,
  parameter int NUM_SET = 64
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  replacer_history_ctrl_if.slave bus
);

  localparam int SET_ADDR_WIDTH = set_addr_width(NUM_SET);

  state_t                    r_state;
  state_t                    w_next_state;
  logic [SET_ADDR_WIDTH-1:0] r_sweep;
  logic [SET_ADDR_WIDTH-1:0] r_set;
  logic                      r_op;
  logic [NUM_WAY-1:0]        r_way;
  logic [NUM_WAY-1:0]        r_valid_vec;
  logic [NUM_WAY-1:0]        r_rd_data;
  logic [NUM_WAY-1:0]        r_resp_way;
  logic [NUM_WAY-1:0]        r_hist [NUM_SET];

  logic                      w_req_fire;
  logic                      w_sweep_done;
  logic [NUM_WAY-1:0]        w_inv_pick;
  logic                      w_inv_found;
  logic [NUM_WAY-1:0]        w_zero_pick;
  logic                      w_zero_found;
  logic [NUM_WAY-1:0]        w_chosen;
  logic [NUM_WAY-1:0]        w_merged;
  logic [NUM_WAY-1:0]        w_new_hist;
  logic                      w_wr_en;
  logic [SET_ADDR_WIDTH-1:0] w_wr_addr;
  logic [NUM_WAY-1:0]        w_wr_data;

  assign w_req_fire   = bus.request_valid_in && (r_state == ST_IDLE);
  assign w_sweep_done = (r_sweep == SET_ADDR_WIDTH'(NUM_SET - 1));

  assign bus.request_ready_out  = (r_state == ST_IDLE);
  assign bus.response_valid_out = (r_state == ST_RESP);
  assign bus.response_way_out   = (r_state == ST_RESP) ? r_resp_way : '0;

  find_first_one_index #(.WIDTH(NUM_WAY)) u_invalid_pick (
    .i_vec   (~r_valid_vec),
    .o_onehot(w_inv_pick),
    .o_found (w_inv_found)
  );

  find_first_one_index #(.WIDTH(NUM_WAY)) u_zero_hist_pick (
    .i_vec   (~r_rd_data),
    .o_onehot(w_zero_pick),
    .o_found (w_zero_found)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) r_state <= ST_INIT;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:   if (w_sweep_done) w_next_state = ST_IDLE;
      ST_IDLE:   if (w_req_fire) w_next_state = ST_READ;
      ST_READ:   w_next_state = ST_UPDATE;
      ST_UPDATE: w_next_state = ST_RESP;
      ST_RESP:   if (bus.response_ready_in) w_next_state = ST_IDLE;
      default:   w_next_state = ST_INIT;
    endcase
  end

  // Once every line is used in an epoch, history restarts from the chosen way.
  always_comb begin
    w_chosen = r_way;
    if (r_op == OP_VICTIM) begin
      if (w_inv_found)       w_chosen = w_inv_pick;
      else if (w_zero_found) w_chosen = w_zero_pick;
      else                   w_chosen = NUM_WAY'(1);
    end
    w_merged   = r_rd_data | w_chosen;
    w_new_hist = (&w_merged) ? w_chosen : w_merged;
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_set;
    w_wr_data = w_new_hist;
    if (r_state == ST_INIT) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_sweep;
      w_wr_data = '0;
    end else if (r_state == ST_UPDATE && (|w_chosen)) begin
      w_wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in && w_wr_en) r_hist[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_sweep     <= '0;
      r_op        <= OP_TOUCH;
      r_set       <= '0;
      r_way       <= '0;
      r_valid_vec <= '0;
      r_rd_data   <= '0;
      r_resp_way  <= '0;
    end else begin
      if (r_state == ST_INIT) r_sweep <= w_sweep_done ? '0 : r_sweep + 1'b1;
      if (w_req_fire) begin
        r_op        <= bus.request_op_in;
        r_set       <= bus.request_set_addr_in;
        r_way       <= bus.request_way_in;
        r_valid_vec <= bus.request_valid_flatted_in;
      end
      if (r_state == ST_READ)   r_rd_data  <= r_hist[r_set];
      if (r_state == ST_UPDATE) r_resp_way <= w_chosen;
    end
  end

endmodule

// File: tb/tb_replacer_history_ctrl.sv
// Self-checking bench for replacer_history_ctrl: directed NRU scenarios
// plus randomized traffic against a per-set history model.
module tb_replacer_history_ctrl;
  import replacer_pkg::*;

  localparam int NUM_WAY = 8;
  localparam int NUM_SET = 64;
  localparam int SAW     = 6;

  logic clk = 1'b0;
  logic reset;
  int   numChecks = 0;
  int   numPassed = 0;
  logic [NUM_WAY-1:0] modelHist [NUM_SET];

  always #5 clk = ~clk;

  replacer_history_ctrl_if #(.NUM_WAY(NUM_WAY), .SET_ADDR_WIDTH(SAW)) bus ();

  replacer_history_ctrl #(.NUM_WAY(NUM_WAY), .NUM_SET(NUM_SET)) dut (
    .clk_in  (clk),
    .reset_in(reset),
    .bus     (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual === expected) numPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Victim rule: first invalid way, else first way not recently used, else way 0.
  function automatic logic [7:0] modelChoose(input logic op, input logic [5:0] set,
                                             input logic [7:0] way, input logic [7:0] valid);
    logic [7:0] pick;
    pick = '0;
    if (op == OP_TOUCH) return way;
    for (int i = 0; i < NUM_WAY; i++)
      if (!valid[i]) begin pick[i] = 1'b1; return pick; end
    for (int i = 0; i < NUM_WAY; i++)
      if (!modelHist[set][i]) begin pick[i] = 1'b1; return pick; end
    return 8'h01;
  endfunction

  task automatic modelUpdate(input logic [5:0] set, input logic [7:0] chosen);
    logic [7:0] merged;
    if (chosen == 8'h00) return;
    merged = modelHist[set] | chosen;
    modelHist[set] = (merged == 8'hFF) ? chosen : merged;
  endtask

  task automatic modelClear();
    for (int s = 0; s < NUM_SET; s++) modelHist[s] = '0;
  endtask

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus.request_ready_out) break;
    end
  endtask

  task automatic applyStimulus(input logic op, input logic [5:0] set, input logic [7:0] way,
                               input logic [7:0] valid, input int hold);
    int guard;
    logic [7:0] expWay;
    @(negedge clk);
    guard = 0;
    while (!bus.request_ready_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.request_ready_out) begin
      checkOutput("req_ready_timeout", 32'(bus.request_ready_out), 32'd1);
      return;
    end
    bus.request_valid_in         = 1'b1;
    bus.request_op_in            = op;
    bus.request_set_addr_in      = set;
    bus.request_way_in           = way;
    bus.request_valid_flatted_in = valid;
    expWay = modelChoose(op, set, way, valid);
    modelUpdate(set, expWay);
    @(posedge clk);
    @(negedge clk);
    bus.request_valid_in         = 1'b0;
    bus.request_way_in           = 8'($urandom);
    bus.request_valid_flatted_in = 8'($urandom);
    checkOutput("read_resp_valid", 32'(bus.response_valid_out), 32'd0);
    checkOutput("read_req_ready", 32'(bus.request_ready_out), 32'd0);
    @(negedge clk);
    checkOutput("update_resp_valid", 32'(bus.response_valid_out), 32'd0);
    @(negedge clk);
    checkOutput("resp_valid", 32'(bus.response_valid_out), 32'd1);
    checkOutput("resp_way", 32'(bus.response_way_out), 32'(expWay));
    repeat (hold) begin
      @(negedge clk);
      checkOutput("hold_resp_valid", 32'(bus.response_valid_out), 32'd1);
      checkOutput("hold_resp_way", 32'(bus.response_way_out), 32'(expWay));
      checkOutput("hold_req_ready", 32'(bus.request_ready_out), 32'd0);
    end
    bus.response_ready_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.response_ready_in = 1'b0;
    checkOutput("post_resp_valid", 32'(bus.response_valid_out), 32'd0);
    checkOutput("post_resp_way", 32'(bus.response_way_out), 32'd0);
    checkOutput("post_req_ready", 32'(bus.request_ready_out), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    logic [7:0] way;
    logic [7:0] valid;
    int sel;

    reset                        = 1'b1;
    bus.request_valid_in         = 1'b0;
    bus.request_op_in            = OP_TOUCH;
    bus.request_set_addr_in      = '0;
    bus.request_way_in           = '0;
    bus.request_valid_flatted_in = '0;
    bus.response_ready_in        = 1'b0;
    modelClear();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(bus.request_ready_out), 32'd0);
    checkOutput("reset_resp_valid", 32'(bus.response_valid_out), 32'd0);
    checkOutput("reset_resp_way", 32'(bus.response_way_out), 32'd0);
    reset = 1'b0;
    waitReady(cycles);
    checkOutput("init_sweep_cycles", 32'(cycles), 32'd64);

    $display("[TB] epoch walk on set 5");
    for (int i = 0; i < 9; i++) applyStimulus(OP_VICTIM, 6'd5, 8'h00, 8'hFF, 0);

    $display("[TB] invalid-way priority on set 3");
    applyStimulus(OP_VICTIM, 6'd3, 8'h00, 8'b1111_0111, 0);
    applyStimulus(OP_TOUCH, 6'd3, 8'h08, 8'hFF, 0);
    applyStimulus(OP_VICTIM, 6'd3, 8'h00, 8'b1111_0111, 0);

    $display("[TB] touch sweep on set 2");
    for (int i = 0; i < 7; i++) begin
      way = '0;
      way[i] = 1'b1;
      applyStimulus(OP_TOUCH, 6'd2, way, 8'hFF, 0);
    end
    applyStimulus(OP_VICTIM, 6'd2, 8'h00, 8'hFF, 0);
    applyStimulus(OP_TOUCH, 6'd2, 8'h80, 8'hFF, 0);
    applyStimulus(OP_VICTIM, 6'd2, 8'h00, 8'hFF, 0);
    applyStimulus(OP_TOUCH, 6'd2, 8'h00, 8'hFF, 0);

    $display("[TB] response backpressure");
    applyStimulus(OP_VICTIM, 6'd9, 8'h00, 8'hFF, 10);

    $display("[TB] reset during update");
    applyStimulus(OP_TOUCH, 6'd0, 8'h01, 8'hFF, 0);
    @(negedge clk);
    bus.request_valid_in         = 1'b1;
    bus.request_op_in            = OP_VICTIM;
    bus.request_set_addr_in      = 6'd0;
    bus.request_valid_flatted_in = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.request_valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_resp_valid", 32'(bus.response_valid_out), 32'd0);
    checkOutput("midreset_resp_way", 32'(bus.response_way_out), 32'd0);
    checkOutput("midreset_req_ready", 32'(bus.request_ready_out), 32'd0);
    modelClear();
    waitReady(cycles);
    checkOutput("resweep_cycles", 32'(cycles), 32'd64);
    applyStimulus(OP_VICTIM, 6'd0, 8'h00, 8'hFF, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      way = 8'h00;
      else if (sel == 1) way = 8'($urandom);
      else begin
        way = '0;
        way[$urandom_range(0, 7)] = 1'b1;
      end
      valid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      applyStimulus(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), way, valid,
                    int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule

// File: doc/replacer_history_ctrl.md
REPLACER_HISTORY_CTRL -- requirements
Module: replacer_history_ctrl

Interface
REQ-001 Parameter NUM_WAY, default 8, ways per set (>=1).
REQ-002 Parameter NUM_SET, default 64, sets tracked; SET_ADDR_WIDTH = max(1, clog2(NUM_SET)).
REQ-003 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 request_valid_in  input  1  request offered.
REQ-006 request_ready_out  output  1  request can be accepted this cycle.
REQ-007 request_op_in  input  1  0 = TOUCH (hit update), 1 = VICTIM (miss victim select).
REQ-008 request_set_addr_in  input  SET_ADDR_WIDTH  target set.
REQ-009 request_way_in  input  NUM_WAY  one-hot used way (TOUCH only).
REQ-010 request_valid_flatted_in  input  NUM_WAY  per-way line-valid bits (VICTIM only).
REQ-011 response_valid_out  output  1  result available.
REQ-012 response_ready_in  input  1  consumer takes result.
REQ-013 response_way_out  output  NUM_WAY  one-hot chosen/touched way.

Function
REQ-014 States: INIT, IDLE, READ, UPDATE, RESP.
REQ-015 INIT clears history of set 0..NUM_SET-1, one set per cycle via sweep counter, then enters IDLE; request_ready_out = 0 throughout.
REQ-016 request_ready_out = 1 only in IDLE; handshake = request_valid_in & request_ready_out; op, set, way, valid vector are registered at handshake.
REQ-017 Handshake at edge T: READ issues history-array read of registered set; edge T+1 enters UPDATE with read data; edge T+2 writes updated history and enters RESP; response_valid_out = 1 from T+2 until response handshake.
REQ-018 VICTIM: chosen = lowest-index way with valid bit 0; else lowest-index way with history bit 0; else way 0.
REQ-019 TOUCH: chosen = request_way_in; multi-hot sets every listed bit; all-zero vector writes nothing and returns all-zero response_way_out.
REQ-020 Update: new = history | chosen; if new is all-ones, new = chosen (NRU epoch reset).
REQ-021 NUM_WAY = 1: VICTIM always returns 1'b1; history remains 1.
REQ-022 response_way_out stable while response_valid_out = 1 and response_ready_in = 0.
REQ-023 Response handshake returns FSM to IDLE; next request accepted no earlier than the following edge (max throughput one request per 4 cycles).
REQ-024 Back-to-back requests to the same set observe the previous write (write completes before next READ).
REQ-025 response_way_out is 0 whenever response_valid_out = 0.

Reset
REQ-026 reset_in asserted in any state forces INIT at next edge, sweep counter = 0, response_valid_out = 0, request_ready_out = 0, response_way_out = 0; any in-flight request is dropped with no response.
REQ-027 History array contents are defined only after INIT completes (NUM_SET cycles after reset release).

Structure
REQ-028 Shared package replacer_pkg holds op encodings (OP_TOUCH, OP_VICTIM) and FSM state encodings.
REQ-029 History storage is an internal NUM_SET x NUM_WAY register array, one write and one registered read per cycle.
REQ-030 Sub-module find_first_one_index (priority picker) is instantiated twice: invalid-way pick and zero-history pick.

Verification
REQ-031 Reset release -> request_ready_out stays 0 for exactly 64 cycles (default), then 1.
REQ-032 VICTIM set 5, valid 8'hFF, history 0 -> response 8'h01; repeat x7 -> 8'h02, 04, ... 80; 8th call then returns 8'h01 after epoch reset to 8'h80 then 8'h01.
REQ-033 VICTIM set 3, valid 8'b1111_0111 -> response 8'h08 regardless of history.
REQ-034 TOUCH set 2 ways 8'h01..8'h40 in turn, then VICTIM set 2 valid 8'hFF -> 8'h80; TOUCH 8'h80 -> history becomes 8'h80.
REQ-035 Response held with response_ready_in = 0 for 10 cycles -> response_way_out constant, request_ready_out = 0 throughout.
REQ-036 reset_in pulsed in UPDATE -> no response, history swept to 0, subsequent VICTIM set 0 valid 8'hFF -> 8'h01.
